// File: rtl/lb_ctrl_pkg.sv
// rtl/lb_ctrl_pkg.sv - shared constants and write-state type for the line-buffer write side
package lb_ctrl_pkg;

   localparam int NUM_BANKS    = 4;
   localparam int LINE_MAX_DEF = 1920;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } lb_wr_state_t;

endpackage

// File: rtl/lb_occ_tracker.sv
// rtl/lb_occ_tracker.sv - bank occupancy counter, oldest-line pointer and full prediction
module lb_occ_tracker
   import lb_ctrl_pkg::*;
(
   input  logic       clk_in1,
   input  logic       rst,
   input  logic       clear,
   input  logic [1:0] commit_req,
   input  logic       line_release,
   output logic [2:0] line_avail,
   output logic [1:0] top_bank,
   output logic       full_after
);

   logic [1:0] commit_q;
   logic       rel_eff;
   logic [3:0] proj;

   assign rel_eff = line_release && (line_avail != 3'd0) && !clear;

   // Occupancy once this beat's commit (and the one still in flight) has landed.
   always_comb begin
      proj = {1'b0, line_avail} + {2'b00, commit_q} + {2'b00, commit_req} - {3'b000, rel_eff};
      if (clear) begin
         proj = {2'b00, commit_req};
      end
      full_after = (proj >= 4'(NUM_BANKS));
   end

   always_ff @(posedge clk_in1) begin
      if (rst) begin
         line_avail <= '0;
         top_bank   <= '0;
         commit_q   <= '0;
      end else if (clear) begin
         line_avail <= '0;
         top_bank   <= '0;
         commit_q   <= commit_req;
      end else begin
         line_avail <= line_avail + {1'b0, commit_q} - {2'b00, rel_eff};
         top_bank   <= top_bank + {1'b0, rel_eff};
         commit_q   <= commit_req;
      end
   end

endmodule

// File: rtl/line_buf_wr_ctrl.sv
// rtl/line_buf_wr_ctrl.sv - pixel stream to 4-bank line buffer write sequencer (option: LB_TOP_REPLICATE_EN)
module line_buf_wr_ctrl
   import lb_ctrl_pkg::*;
#(
   parameter int LINE_MAX = LINE_MAX_DEF,
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 8
) (
   input  logic              clk_in1,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_sof,
   input  logic              s_eol,
   output logic              bram0_wenb,
   output logic              bram1_wenb,
   output logic              bram2_wenb,
   output logic              bram3_wenb,
   output logic [ADDR_W-1:0] bram_waddr,
   output logic [DATA_W-1:0] bram_wdata,
   output logic [2:0]        line_avail,
   output logic [1:0]        top_bank,
   input  logic              line_release,
   output logic [ADDR_W:0]   line_len,
   output logic              frame_start,
   output logic              err_ovf
);

   localparam logic [ADDR_W:0] LMAX = (ADDR_W+1)'(LINE_MAX);

   lb_wr_state_t      state, state_nxt;
   logic [ADDR_W:0]   pix_cnt;
   logic [1:0]        wr_bank, base_bank;
   logic [3:0]        wenb, wenb_nxt;
   logic [ADDR_W-1:0] wr_addr;
   logic [1:0]        commit_req;
   logic beat, sof_beat, in_line, eol_beat, ovf, wr_en, rep, full_after;

`ifdef LB_TOP_REPLICATE_EN
   logic first_line;

   always_ff @(posedge clk_in1) begin
      if (rst)           first_line <= 1'b0;
      else if (eol_beat) first_line <= 1'b0;
      else if (sof_beat) first_line <= 1'b1;
   end
`endif

   always_comb begin
      s_ready   = (state != FULL);
      beat      = s_valid && s_ready;
      sof_beat  = beat && s_sof;
      in_line   = sof_beat || (beat && state == FILL);
      eol_beat  = in_line && s_eol;
      ovf       = in_line && !sof_beat && (pix_cnt == LMAX);
      wr_en     = in_line && !ovf;
      base_bank = sof_beat ? 2'd0 : wr_bank;
      wr_addr   = sof_beat ? '0 : pix_cnt[ADDR_W-1:0];
`ifdef LB_TOP_REPLICATE_EN
      // The frame's first line also fills bank 1 so the top row has a y-1 tap.
      rep = sof_beat || first_line;
`else
      rep = 1'b0;
`endif
      wenb_nxt = '0;
      if (wr_en) begin
         if (rep) wenb_nxt = 4'b0011;
         else     wenb_nxt[base_bank] = 1'b1;
      end
      commit_req = '0;
      if (eol_beat) commit_req = rep ? 2'd2 : 2'd1;
   end

   always_ff @(posedge clk_in1) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (in_line) begin
         state_nxt = (eol_beat && full_after) ? FULL : FILL;
      end else if (state == FULL && line_release) begin
         state_nxt = FILL;
      end
   end

   always_ff @(posedge clk_in1) begin
      if (rst) begin
         pix_cnt     <= '0;
         wr_bank     <= '0;
         wenb        <= '0;
         bram_waddr  <= '0;
         bram_wdata  <= '0;
         line_len    <= '0;
         frame_start <= 1'b0;
         err_ovf     <= 1'b0;
      end else begin
         wenb        <= wenb_nxt;
         frame_start <= sof_beat;
         if (wr_en) begin
            bram_waddr <= wr_addr;
            bram_wdata <= s_data;
         end
         if (ovf) err_ovf <= 1'b1;
         if (eol_beat) begin
            pix_cnt  <= '0;
            wr_bank  <= rep ? 2'd2 : base_bank + 2'd1;
            line_len <= sof_beat ? (ADDR_W+1)'(1) : (pix_cnt == LMAX) ? LMAX : pix_cnt + 1'b1;
         end else if (sof_beat) begin
            pix_cnt <= (ADDR_W+1)'(1);
            wr_bank <= '0;
         end else if (wr_en) begin
            pix_cnt <= pix_cnt + 1'b1;
         end
      end
   end

   assign bram0_wenb = wenb[0];
   assign bram1_wenb = wenb[1];
   assign bram2_wenb = wenb[2];
   assign bram3_wenb = wenb[3];

   lb_occ_tracker u_occ (
      .clk_in1      (clk_in1),
      .rst          (rst),
      .clear        (sof_beat),
      .commit_req   (commit_req),
      .line_release (line_release),
      .line_avail   (line_avail),
      .top_bank     (top_bank),
      .full_after   (full_after)
   );

endmodule

// File: tb/tb_line_buf_wr_ctrl.sv
// tb/tb_line_buf_wr_ctrl.sv - scoreboard bench for line_buf_wr_ctrl (LINE_MAX=8)
module tb_line_buf_wr_ctrl;

   localparam int AW = 11;
   localparam int DW = 8;
   localparam int LM = 8;
`ifdef LB_TOP_REPLICATE_EN
   localparam bit REPL = 1'b1;
`else
   localparam bit REPL = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, s_valid, s_ready, s_sof, s_eol, line_release;
   logic [DW-1:0] s_data, bram_wdata;
   logic [AW-1:0] bram_waddr;
   logic [AW:0]   line_len;
   logic [2:0]    line_avail;
   logic [1:0]    top_bank;
   logic          frame_start, err_ovf;
   logic          w0, w1, w2, w3;
   logic [3:0]    wenb;
   assign wenb = {w3, w2, w1, w0};

   line_buf_wr_ctrl #(.LINE_MAX(LM), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_in1(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_sof(s_sof), .s_eol(s_eol), .bram0_wenb(w0), .bram1_wenb(w1), .bram2_wenb(w2),
      .bram3_wenb(w3), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
      .line_avail(line_avail), .top_bank(top_bank), .line_release(line_release),
      .line_len(line_len), .frame_start(frame_start), .err_ovf(err_ovf)
   );

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];
   bit          m_in = 1'b0;
   bit          m_first = 1'b0;
   int          m_pix = 0;
   logic [1:0]  m_bank = 2'd0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [31:0] mon_got;
   always @(negedge clk) begin
      if (wenb != 4'b0) begin
         mon_got = {9'b0, wenb, bram_waddr, bram_wdata};
         if (exp_q.size() == 0) check("wr_unexp", mon_got, 32'h0);
         else                   check("wr", mon_got, exp_q.pop_front());
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_beat(input logic [7:0] d, input bit sof, input bit eol);
      int n;
      logic [3:0] mask;
      n = 0;
      s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
      while (!s_ready && n < 20) begin
         cyc(1);
         n++;
      end
      if (!s_ready) begin
         check("ready_timeout", {31'b0, s_ready}, 32'd1);
         s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
         return;
      end
      cyc(1);
      s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
      if (sof) begin
         m_in = 1'b1; m_bank = 2'd0; m_pix = 0; m_first = REPL;
      end
      if (m_in) begin
         mask = m_first ? 4'b0011 : (4'b0001 << m_bank);
         if (m_pix < LM) begin
            exp_q.push_back({9'b0, mask, 11'(m_pix), d});
            m_pix++;
         end
         if (eol) begin
            m_pix = 0;
            m_bank = m_first ? 2'd2 : m_bank + 2'd1;
            m_first = 1'b0;
         end
      end
   endtask

   task automatic send_px(input logic [7:0] base, input int first, input int last, input bit eol_last);
      for (int x = first; x <= last; x++)
         push_beat(base + 8'(x), 1'b0, eol_last && (x == last));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0; s_data = '0; line_release = 1'b0;
      cyc(3);
      rst = 1'b0;
      check("rst_state", {20'b0, s_ready, line_avail, top_bank, err_ovf, frame_start, wenb}, 32'h800);
      check("rst_len", 32'(line_len), 32'd0);
      check("rst_wr", {13'b0, bram_waddr, bram_wdata}, 32'd0);
      push_beat(8'hAA, 1'b0, 1'b0);

`ifdef LB_TOP_REPLICATE_EN
      push_beat(8'h00, 1'b1, 1'b0);
      send_px(8'h00, 1, 3, 1'b1);
      check("rep_ready", {31'b0, s_ready}, 32'd1);
      cyc(1);
      check("rep_avail", 32'(line_avail), 32'd2);
      push_beat(8'h10, 1'b0, 1'b0);
      cyc(2);
`else
      push_beat(8'h00, 1'b1, 1'b0);
      check("frame_start", {31'b0, frame_start}, 32'd1);
      send_px(8'h00, 1, 7, 1'b1);
      for (int l = 1; l < 4; l++) send_px(8'(l * 16), 0, 7, 1'b1);
      check("ready_fall", {31'b0, s_ready}, 32'd0);
      check("avail_pre", 32'(line_avail), 32'd3);
      cyc(1);
      check("avail_full", 32'(line_avail), 32'd4);
      check("len8", 32'(line_len), 32'd8);
      cyc(3);
      check("stall", {31'b0, s_ready}, 32'd0);
      check("top0", 32'(top_bank), 32'd0);

      line_release = 1'b1;
      cyc(1);
      line_release = 1'b0;
      check("rel_ready", {31'b0, s_ready}, 32'd1);
      check("rel_top", 32'(top_bank), 32'd1);
      check("rel_avail", 32'(line_avail), 32'd3);
      send_px(8'h40, 0, 7, 1'b1);
      cyc(1);
      check("refill_avail", 32'(line_avail), 32'd4);
      check("refill_ready", {31'b0, s_ready}, 32'd0);

      line_release = 1'b1;
      cyc(2);
      line_release = 1'b0;
      check("rel2_avail", 32'(line_avail), 32'd2);
      check("rel2_top", 32'(top_bank), 32'd3);
      send_px(8'h50, 0, 7, 1'b1);
      line_release = 1'b1;
      cyc(1);
      line_release = 1'b0;
      check("sim_avail", 32'(line_avail), 32'd2);
      check("sim_top", 32'(top_bank), 32'd0);

      check("ovf_pre", {31'b0, err_ovf}, 32'd0);
      send_px(8'h60, 0, 7, 1'b0);
      check("ovf_edge", {31'b0, err_ovf}, 32'd0);
      send_px(8'h60, 8, 9, 1'b0);
      push_beat(8'h6F, 1'b0, 1'b1);
      check("ovf_flag", {31'b0, err_ovf}, 32'd1);
      check("ovf_len", 32'(line_len), 32'd8);
      cyc(1);
      check("ovf_avail", 32'(line_avail), 32'd3);

      send_px(8'h70, 0, 4, 1'b0);
      push_beat(8'h99, 1'b1, 1'b0);
      check("rs_fs", {31'b0, frame_start}, 32'd1);
      check("rs_avail", 32'(line_avail), 32'd0);
      check("rs_top", 32'(top_bank), 32'd0);
      cyc(1);
      check("rs_fs_end", {31'b0, frame_start}, 32'd0);
      send_px(8'h98, 2, 4, 1'b1);
      check("rs_len", 32'(line_len), 32'd4);
      cyc(1);
      check("rs_avail1", 32'(line_avail), 32'd1);

      push_beat(8'hB0, 1'b0, 1'b0);
      rst = 1'b1; s_valid = 1'b1; s_data = 8'hEE;
      cyc(1);
      rst = 1'b0; s_valid = 1'b0;
      m_in = 1'b0; m_pix = 0; m_bank = 2'd0;
      check("mr_avail", 32'(line_avail), 32'd0);
      check("mr_ovf", {31'b0, err_ovf}, 32'd0);
      check("mr_ready", {31'b0, s_ready}, 32'd1);
      cyc(2);
`endif
      check("wr_pending", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/line_buf_wr_ctrl.md
# line_buf_wr_ctrl

Write-side sequencer for the 4-line, 16-read-port bicubic line-buffer bank. It accepts an 8-bit pixel stream and writes each input line into one of four line banks in round-robin order, driving the bank's `bram0..3_wenb`, `bram_waddr` and `bram_wdata` inputs. It tracks bank occupancy and exposes a line-available/release handshake to the interpolation read scheduler, so that no bank is overwritten before the read side has released it.

## Interface

**Parameters**
- `LINE_MAX`, default 1920: maximum pixels per line; must be ≤ 2^ADDR_W.
- `ADDR_W`, default 11: bank address width.
- `DATA_W`, default 8: pixel width.

**Ports**
- `clk_in1` in 1: single clock. Both the write stream and the handshake run on it.
- `rst` in 1: reset, synchronous, active-high.
- `s_valid` in 1: input pixel valid.
- `s_ready` out 1: input pixel accepted when `s_valid && s_ready`.
- `s_data` in DATA_W: pixel value.
- `s_sof` in 1: first pixel of frame; qualified by the beat.
- `s_eol` in 1: last pixel of line; qualified by the beat.
- `bram0_wenb` .. `bram3_wenb` out 1 each: per-bank write enables.
- `bram_waddr` out ADDR_W: write address, shared by all banks.
- `bram_wdata` out DATA_W: write data, shared by all banks.
- `line_avail` out 3: completed, unreleased lines (0..4).
- `top_bank` out 2: bank index holding the oldest unreleased line.
- `line_release` in 1: read side frees the oldest line.
- `line_len` out ADDR_W+1: pixel count of the most recently completed line.
- `frame_start` out 1: one-cycle pulse on an accepted `s_sof` beat.
- `err_ovf` out 1: sticky flag, set when a line exceeds `LINE_MAX`.

## Operation

**States**
- `IDLE`: wait for a `s_sof` beat. Beats without `s_sof` are accepted and dropped.
- `FILL`: write the current line into bank `wr_bank`.
- `FULL`: no free bank; `s_ready`=0.

**Transitions**
- `IDLE` → `FILL` on a `s_sof` beat.
- `FILL` → `FULL` on an `s_eol` beat when the occupancy after commit would leave no free bank.
- `FULL` → `FILL` on `line_release`.

**Writes and pointers**
- `s_ready` = (state≠`FULL`) in `IDLE`/`FILL`.
- An accepted beat in `FILL` (or the `s_sof` beat) writes `s_data` to `wr_bank` at address `pix_cnt`, then `pix_cnt++`.
- An `s_eol` beat does the following: `line_len` ← `pix_cnt`+1, `pix_cnt` ← 0, `wr_bank` ← (`wr_bank`+1) mod 4, and the line is committed.

**Overflow**
- Beats arriving when `pix_cnt` = `LINE_MAX` are not written, and `err_ovf` ← 1.
- A later `s_eol` still closes the line, with `line_len` = `LINE_MAX`.

**Occupancy**
- `line_avail` increments on commit and decrements on `line_release`.
- Simultaneous commit and release: count unchanged, `top_bank` advances.
- `line_release` with `line_avail`=0 is ignored.
- `top_bank` ← `top_bank`+1 on each effective release.

**Frame resync**
- `s_sof` accepted in `FILL` aborts the partial line.
- It resets `wr_bank`, `top_bank` and `line_avail` to 0, and the `s_sof` pixel is written at bank 0 address 0.
- `s_sof` is never accepted in `FULL`.

## Timing

- **Reset values:** all wenb=0, `bram_waddr`=0, `bram_wdata`=0, `line_avail`=0, `top_bank`=0, `line_len`=0, `frame_start`=0, `err_ovf`=0, state `IDLE`. `s_ready`=1 in the cycle after `rst` falls.
- **Write latency:** write outputs are registered. Beat at cycle N gives wenb/addr/data valid at N+1, for exactly one cycle.
- **Commit latency:** `line_avail` increments at N+2 for an `s_eol` beat at N, i.e. one cycle after the last wenb.
- **Ready latency:** `s_ready` deasserts in the cycle after the filling `s_eol` beat and reasserts the cycle after `line_release`.
- **Reset mid-line:** discards all state. No wenb is issued after the `rst` cycle.

## Configuration

- Macro `LB_TOP_REPLICATE_EN`.
- **Defined:** the first line of each frame is written simultaneously to banks 0 and 1 (two wenbs high) and commits as two lines (`line_avail` +2, `wr_bank` ← 2). This supplies the y−1 tap for the top row. A second bank must be free, which it always is after resync.
- **Undefined:** every line occupies exactly one bank.

## Structure

- Shared package `lb_ctrl_pkg`:
  - `NUM_BANKS`=4
  - state enum `lb_wr_state_t` {`IDLE`, `FILL`, `FULL`}
  - default `LINE_MAX`
- One sub-module `lb_occ_tracker`: owns `line_avail`, `top_bank`, the commit/release arithmetic and the full flag.

## Test plan

- **Basic fill.** Reset; sof, then 4 lines of 8 pixels each (data = line·16+x); no release.
  - wenb0..3 in turn, addresses 0..7.
  - `line_avail`=4, `s_ready`=0, `line_len`=8.
- **Stall and release.** With the bank full, pulse `line_release` once.
  - `top_bank`=1, `line_avail`=3, `s_ready`=1 next cycle.
  - The 5th line writes bank 0.
- **Simultaneous commit and release.** Assert release on the same cycle the commit lands.
  - `line_avail` unchanged, `top_bank` +1.
- **Overflow.** `LINE_MAX`=8; send 10 pixels, then eol.
  - Only addresses 0..7 are written.
  - `err_ovf`=1, `line_len`=8.
- **Resync.** sof at pixel 5 of line 2.
  - `line_avail`=0, `top_bank`=0, `frame_start` pulse, write to bank 0 address 0.
- **Top replicate (`LB_TOP_REPLICATE_EN`).** Send the first line of 4 pixels.
  - wenb0 and wenb1 high together.
  - `line_avail`=2; the next line writes bank 2.
